// File: rtl/counter_sched.sv
// Round-robin scheduler that time-shares one external counter between NUM_REQ
// requesters: optional load, then N increments, then a done pulse with the result.
module counter_sched #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 4,
    parameter int STEP_W  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ-1:0]          req_load_i,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data_i,
    input  logic [NUM_REQ*STEP_W-1:0]   req_steps_i,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [WIDTH-1:0]            result_o,
    output logic                        busy_o,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
    output logic                        cnt_enable_o,
    output logic                        cnt_load_o,
    output logic [WIDTH-1:0]            cnt_data_o,
    input  logic [WIDTH-1:0]            cnt_count_i
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   data_reg;
    logic [STEP_W-1:0]  steps_reg;
    logic [GW-1:0]      grant_id_reg;
    logic [GW-1:0]      last_grant_reg;
    logic [WIDTH-1:0]   result_reg;

    logic [WIDTH-1:0]   data_arr  [NUM_REQ];
    logic [STEP_W-1:0]  steps_arr [NUM_REQ];
    logic               pick_valid;
    logic [GW-1:0]      pick_idx;
    logic [GW-1:0]      cand;
    logic               take;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi]  = req_data_i[gi*WIDTH +: WIDTH];
            assign steps_arr[gi] = req_steps_i[gi*STEP_W +: STEP_W];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest valid after last_grant wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = GW'((int'(last_grant_reg) + off) % NUM_REQ);
            if (req_valid_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign take = (state_reg == IDLE) && pick_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (take) begin
                    if (req_load_i[pick_idx])
                        state_next = LOAD;
                    else if (steps_arr[pick_idx] != '0)
                        state_next = RUN;
                    else
                        state_next = DONE;
                end
            end
            LOAD:    state_next = (steps_reg != '0) ? RUN : DONE;
            RUN:     state_next = (steps_reg == STEP_W'(1)) ? DONE : RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_reg       <= '0;
            steps_reg      <= '0;
            grant_id_reg   <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            result_reg     <= '0;
        end else begin
            if (take) begin
                data_reg       <= data_arr[pick_idx];
                steps_reg      <= steps_arr[pick_idx];
                grant_id_reg   <= pick_idx;
                last_grant_reg <= pick_idx;
            end else if (state_reg == RUN) begin
                steps_reg <= steps_reg - STEP_W'(1);
            end
            if (state_reg == DONE) begin
                result_reg <= cnt_count_i;
            end
        end
    end

    // The final count only exists during DONE, so it is forwarded there and held afterwards.
    always_comb begin
        busy_o       = (state_reg != IDLE);
        cnt_enable_o = (state_reg == LOAD) || (state_reg == RUN);
        cnt_load_o   = (state_reg == LOAD);
        cnt_data_o   = (state_reg == LOAD) ? data_reg : '0;
        grant_id_o   = grant_id_reg;
        result_o     = (state_reg == DONE) ? cnt_count_i : result_reg;
        done_o       = '0;
        if (state_reg == DONE) begin
            done_o[grant_id_reg] = 1'b1;
        end
        req_ready_o = '0;
        if (take) begin
            req_ready_o[pick_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Randomised scoreboard bench for counter_sched with an external 4-bit counter model.
module tb_counter_sched;
    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 4;
    localparam int STEP_W  = 4;
    localparam int GW      = 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid, req_ready, req_load, done;
    logic [NUM_REQ*WIDTH-1:0]  req_data;
    logic [NUM_REQ*STEP_W-1:0] req_steps;
    logic [WIDTH-1:0]          result, cnt_data, cnt_count;
    logic                      busy, cnt_enable, cnt_load;
    logic [GW-1:0]             grant_id;

    logic                      v_valid [NUM_REQ];
    logic                      v_load  [NUM_REQ];
    logic [WIDTH-1:0]          v_data  [NUM_REQ];
    logic [STEP_W-1:0]         v_steps [NUM_REQ];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         idx;
        logic [3:0] res;
        int         due;
    } exp_t;
    exp_t sb_q[$];
    logic [NUM_REQ-1:0] done_log[$];

    counter_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_load_i(req_load),
        .req_data_i(req_data), .req_steps_i(req_steps),
        .done_o(done), .result_o(result), .busy_o(busy), .grant_id_o(grant_id),
        .cnt_enable_o(cnt_enable), .cnt_load_o(cnt_load), .cnt_data_o(cnt_data),
        .cnt_count_i(cnt_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External counter datapath
    always @(posedge clk) begin
        if (rst)             cnt_count <= '0;
        else if (cnt_enable) cnt_count <= cnt_load ? cnt_data : cnt_count + 4'd1;
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_valid[k]                   = v_valid[k];
            req_load[k]                    = v_load[k];
            req_data[k*WIDTH +: WIDTH]     = v_data[k];
            req_steps[k*STEP_W +: STEP_W]  = v_steps[k];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got nothing expected event (cycle %0d)", nm, cyc);
    endtask

    // Reference model: one command in flight, round-robin choice, count arithmetic mod 16.
    int         m_last = NUM_REQ - 1;
    int         m_gid  = 0;
    logic [3:0] m_count = '0;
    logic [3:0] m_last_res = '0;
    bit         act = 0;
    int         act_t, act_due;
    bit         act_ld;
    logic [3:0] act_data, act_res;
    logic [NUM_REQ-1:0] exp_ready;
    bit         can_grant, found;
    int         cand_i, win;

    always @(negedge clk) begin
        if (rst) begin
            m_last = NUM_REQ - 1;
            m_gid = 0;
            m_count = '0;
            m_last_res = '0;
            act = 0;
            sb_q.delete();
        end else begin
            chk("busy", busy, act && cyc > act_t && cyc <= act_due);
            chk("cnt_enable", cnt_enable, act && cyc > act_t && cyc < act_due);
            chk("cnt_load", cnt_load, act && act_ld && cyc == act_t + 1);
            chk("cnt_data", cnt_data, (act && act_ld && cyc == act_t + 1) ? act_data : 4'h0);
            chk("grant_id", grant_id, m_gid);
            if (!(act && cyc == act_due)) chk("result_hold", result, m_last_res);
            can_grant = !act;
            if (act && cyc == act_due) begin
                m_last_res = act_res;
                act = 0;
            end
            exp_ready = '0;
            found = 0;
            win = 0;
            if (can_grant) begin
                for (int off = 1; off <= NUM_REQ; off++) begin
                    cand_i = (m_last + off) % NUM_REQ;
                    if (!found && v_valid[cand_i]) begin
                        found = 1;
                        win = cand_i;
                    end
                end
            end
            if (found) begin
                exp_ready[win] = 1'b1;
                act = 1;
                act_t = cyc;
                act_ld = v_load[win];
                act_data = v_data[win];
                act_due = cyc + (v_load[win] ? 1 : 0) + int'(v_steps[win]) + 1;
                act_res = (v_load[win] ? v_data[win] : m_count) + v_steps[win];
                m_count = act_res;
                m_last = win;
                m_gid = win;
                sb_q.push_back('{idx: win, res: act_res, due: act_due});
            end
            chk("req_ready", req_ready, exp_ready);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    exp_t e;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                fail_now("missed_done");
                void'(sb_q.pop_front());
            end
            if (done !== '0) begin
                done_log.push_back(done);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("done req%0d result=%h cycle %0d", e.idx, result, cyc);
                    chk("done_vec", done, 32'(1 << e.idx));
                    chk("done_result", result, e.res);
                    chk("done_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic issue(input int k, input bit ld, input logic [3:0] d, input logic [3:0] s,
                         input bit tentative, output bit acc);
        int waited;
        waited = 0;
        acc = 0;
        @(posedge clk); #2;
        v_valid[k] = 1'b1;
        v_load[k]  = ld;
        v_data[k]  = d;
        v_steps[k] = s;
        while (!acc) begin
            @(negedge clk);
            if (req_ready[k]) acc = 1;
            else if (tentative || waited > 300) break;
            waited++;
        end
        @(posedge clk); #2;
        v_valid[k] = 1'b0;
        v_load[k]  = 1'($urandom);
        v_data[k]  = 4'($urandom);
        v_steps[k] = 4'($urandom);
        if (!acc && !tentative) fail_now("issue_timeout");
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || busy) && w < 400) begin
            @(posedge clk);
            w++;
        end
        #2;
        if (w >= 400) fail_now("drain_timeout");
    endtask

    task automatic rand_driver(input int k);
        bit acc;
        repeat (25) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(k, 1'($urandom), 4'($urandom), 4'($urandom_range(0, 9)),
                  $urandom_range(0, 4) == 0, acc);
        end
    endtask

    bit acc0, acc1;

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            v_valid[k] = 1'b0;
            v_load[k]  = 1'b0;
            v_data[k]  = '0;
            v_steps[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_enable", cnt_enable, 0);
            chk("idle_outputs", {done, result, busy, grant_id, cnt_load, cnt_data, req_ready}, 0);
        end

        issue(0, 1'b1, 4'hA, 4'd3, 1'b0, acc0);
        drain();
        chk("tp_load_run", result, 4'hD);

        issue(0, 1'b1, 4'hF, 4'd0, 1'b0, acc0);
        issue(1, 1'b0, 4'h0, 4'd2, 1'b0, acc1);
        drain();
        chk("tp_wrap", result, 4'h1);

        done_log.delete();
        fork
            begin issue(0, 1'b0, 4'h0, 4'd1, 1'b0, acc0); issue(0, 1'b0, 4'h0, 4'd1, 1'b0, acc0); end
            begin issue(1, 1'b0, 4'h0, 4'd1, 1'b0, acc1); issue(1, 1'b0, 4'h0, 4'd1, 1'b0, acc1); end
        join
        drain();
        chk("rr_count", done_log.size(), 4);
        if (done_log.size() == 4) begin
            chk("rr_order0", done_log[0], 2'b01);
            chk("rr_order1", done_log[1], 2'b10);
            chk("rr_order2", done_log[2], 2'b01);
            chk("rr_order3", done_log[3], 2'b10);
        end

        issue(0, 1'b1, 4'h7, 4'd0, 1'b0, acc0);
        drain();
        chk("tp_load_only", result, 4'h7);
        issue(0, 1'b0, 4'h0, 4'd0, 1'b0, acc0);
        drain();
        chk("tp_zero_steps", result, 4'h7);

        done_log.delete();
        issue(1, 1'b0, 4'h0, 4'd8, 1'b0, acc1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_enable", cnt_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done_log.size(), 0);
        fork
            issue(1, 1'b0, 4'h0, 4'd1, 1'b0, acc1);
            issue(0, 1'b0, 4'h0, 4'd1, 1'b0, acc0);
        join
        drain();
        chk("abort_regrant_count", done_log.size(), 2);
        if (done_log.size() == 2) chk("abort_regrant_first", done_log[0], 2'b01);

        fork
            rand_driver(0);
            rand_driver(1);
        join
        drain();
        repeat (3) @(posedge clk);
        chk("final_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler sharing one 4-bit counter datapath (enable/load/data/count interface) between NUM_REQ requesters.
- Each requester submits one command: optional load of a start value, then a step count of increments.
- Block sequences the counter's enable/load inputs, returns the final count to the granted requester and pulses that requester's done.
- Sits between software-facing request ports and the counter instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
WIDTH, 4, counter data width
STEP_W, 4, width of step-count field

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  per-requester command valid, held until ready
req_ready_o  out  NUM_REQ  per-requester accept, one-hot, single-cycle
req_load_i  in  NUM_REQ  per-requester: 1 = load req_data first
req_data_i  in  NUM_REQ*WIDTH  per-requester load value, requester k at [k*WIDTH +: WIDTH]
req_steps_i  in  NUM_REQ*STEP_W  per-requester increment count, requester k at [k*STEP_W +: STEP_W]
done_o  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester
result_o  out  WIDTH  counter value, valid in the done cycle, held until next done
busy_o  out  1  high in any state other than IDLE
grant_id_o  out  $clog2(NUM_REQ)  index of current or last granted requester
cnt_enable_o  out  1  counter enable
cnt_load_o  out  1  counter load select
cnt_data_o  out  WIDTH  counter load data
cnt_count_i  in  WIDTH  counter current value

Behaviour:
- Reset (rst_i=1 at edge):
  - State = IDLE.
  - All outputs 0: req_ready_o, done_o, result_o, busy_o, grant_id_o, cnt_*.
  - RR pointer set so requester 0 has highest priority at the first arbitration.
  - Reset mid-operation: in-flight command is dropped, no done pulse, cnt_enable_o=0 from the next cycle.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_valid_i, pick the first valid index searching upward (wrapping) from last_grant+1.
  - Assert req_ready_o[g] combinationally in the same cycle.
  - Latch load flag, data and steps into internal registers; update grant_id_o and last_grant.
  - Next state: LOAD if load=1; else RUN if steps!=0; else DONE.
  - No valid: stay IDLE, req_ready_o=0.
- LOAD (exactly 1 cycle):
  - cnt_enable_o=1, cnt_load_o=1, cnt_data_o=latched data.
  - Next state: RUN if steps!=0, else DONE.
- RUN (exactly steps cycles):
  - cnt_enable_o=1, cnt_load_o=0.
  - Remaining counter decrements each cycle; leave for DONE after the cycle where remaining==1.
- DONE (1 cycle):
  - done_o[g]=1; result_o registered from cnt_count_i (value after the final counter edge); busy_o=1.
  - Next state: IDLE.
- cnt_* outputs and busy_o decode from registered state only. No combinational path from req_* inputs to cnt_* outputs.
- cnt_data_o=0 when not in LOAD.
- Latency, command accepted at cycle T with load=1, steps=S>0: LOAD at T+1, RUN T+2..T+1+S, DONE at T+2+S. Without load: RUN T+1..T+S, DONE T+S+1.
- Throughput: next grant no earlier than the cycle after DONE; IDLE is always visited between commands.
- Counter wrap (15->0) is the datapath's behaviour; the scheduler neither detects nor blocks it.
- Steps=0 with load=0: DONE at T+1, result = unchanged count.
- Requester deasserting valid before ready: permitted, the command is simply not taken. Inputs of non-granted requesters are ignored.
- Simultaneous valid on all requesters: strict rotation, each granted once per NUM_REQ grants.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, cnt_enable_o never high.
- Req0 load=1 data=4'hA steps=3 -> ready0 at T, load pulse T+1 with data A, enable T+2..T+4, done0 at T+5, result_o=4'hD.
- Req1 load=0 steps=2 with counter at 4'hF -> wraps, done1 with result_o=4'h1.
- Req0 and req1 valid together, continuously, 4 commands (steps=1) -> grant order 0,1,0,1; one done per command to the matching requester.
- Req0 load=1 data=7 steps=0 -> single load cycle, done0 at T+2, result_o=7; then load=0 steps=0 -> done at T+1, result_o=7.
- rst_i asserted during RUN of a steps=8 command -> next cycle IDLE, cnt_enable_o=0, no done_o; new request then granted to requester 0.
